// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_arbiter
// Description : Two-requester arbiter sharing one combinational N x M array
//               multiplier. Define MUL_ARB_RR_EN for round-robin arbitration;
//               fixed priority (requester 0 wins) otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_arbiter #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [N-1:0]     a0,
    input  logic [N-1:0]     a1,
    input  logic [M-1:0]     b0,
    input  logic [M-1:0]     b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [M+N-1:0]   res,
    output logic             res_id,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_a;
    logic [M-1:0]     r_b;
    logic             r_id;
    logic [M+N-1:0]   r_res;
    logic             r_res_id;
    logic [15:0]      r_ops_done;
    logic             w_pick1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic [M+N-1:0]   w_pp [M];
    logic [M+N-1:0]   w_prod;

`ifdef MUL_ARB_RR_EN
    logic r_last;

    // On contention, requester 1 wins only if requester 0 was granted last.
    always_comb w_pick1 = req1 && (!req0 || !r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_gnt0 || w_gnt1) begin
            r_last <= w_pick1;
        end
    end
`else
    always_comb w_pick1 = req1 && !req0;
`endif

    // Array multiplier: one shifted partial product per bit of B.
    generate
        for (genvar j = 0; j < M; j++) begin : g_pp
            assign w_pp[j] = r_b[j] ? ({{M{1'b0}}, r_a} << j) : '0;
        end
    endgenerate

    always_comb begin
        w_prod = '0;
        for (int j = 0; j < M; j++) begin
            w_prod = w_prod + w_pp[j];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            IDLE: begin
                if ((req0 || req1) && !rst) begin
                    w_gnt0      = !w_pick1;
                    w_gnt1      = w_pick1;
                    w_state_nxt = MUL;
                end
            end
            MUL:     w_state_nxt = OUT;
            OUT:     if (res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_res      <= '0;
            r_res_id   <= 1'b0;
            r_ops_done <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0 || w_gnt1) begin
                r_a  <= w_pick1 ? a1 : a0;
                r_b  <= w_pick1 ? b1 : b0;
                r_id <= w_pick1;
            end
            if (r_state == MUL) begin
                r_res    <= w_prod;
                r_res_id <= r_id;
            end
            if (r_state == OUT && res_ready) begin
                r_ops_done <= r_ops_done + 16'd1;
            end
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign res       = r_res;
    assign res_id    = r_res_id;
    assign res_valid = (r_state == OUT) && !rst;
    assign ops_done  = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_arbiter
// Description : Directed self-checking bench for mul_arbiter (N = M = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] a0, a1, b0, b1;
    logic       gnt0, gnt1;
    logic [7:0] res;
    logic       res_id;
    logic       res_valid;
    logic       res_ready;
    logic [15:0] ops_done;

    int tests_run    = 0;
    int tests_failed = 0;

    mul_arbiter #(.N(4), .M(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .res(res), .res_id(res_id), .res_valid(res_valid),
        .res_ready(res_ready), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction with res_ready high and returns what was seen.
    task automatic run_op(input logic r0, input logic r1,
                          input logic [3:0] x0, input logic [3:0] y0,
                          input logic [3:0] x1, input logic [3:0] y1,
                          output logic g0, output logic g1,
                          output logic v, output logic [7:0] r, output logic id);
        req0 = r0; req1 = r1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        res_ready = 1'b1;
        #1;
        g0 = gnt0; g1 = gnt1;
        step();
        a0 = 4'($urandom); b0 = 4'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom);
        step();
        v = res_valid; r = res; id = res_id;
        step();
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        a0 = 4'd1; b0 = 4'd1; a1 = 4'd1; b1 = 4'd1; res_ready = 1'b0;
        step(); step();
        tests_run++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_gnt: got %b%b, want 00", gnt0, gnt1);
        end
        tests_run++;
        if (res !== 8'd0 || res_id !== 1'b0 || res_valid !== 1'b0 || ops_done !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: res=%0d id=%b valid=%b ops=%0d, want all 0",
                     res, res_id, res_valid, ops_done);
        end
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic g0, g1, v, id;
        logic [7:0] r;
        run_op(1'b1, 1'b0, 4'd7, 4'd9, 4'd0, 4'd0, g0, g1, v, r, id);
        tests_run++;
        if (g0 !== 1'b1 || g1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_gnt: got %b%b, want 10", g0, g1);
        end
        tests_run++;
        if (v !== 1'b1 || r !== 8'd63 || id !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_res: valid=%b res=%0d id=%b, want 1 63 0", v, r, id);
        end
        tests_run++;
        if (ops_done !== 16'd1 || res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_accept: ops=%0d valid=%b, want 1 0", ops_done, res_valid);
        end
    endtask

    task automatic test_contention();
        logic g0, g1, v, id;
        logic [7:0] r;
        logic [7:0] exp_r  [3];
        logic       exp_id [3];
`ifdef MUL_ARB_RR_EN
        exp_r  = '{8'd225, 8'd15, 8'd225};
        exp_id = '{1'b0, 1'b1, 1'b0};
`else
        exp_r  = '{8'd225, 8'd225, 8'd225};
        exp_id = '{1'b0, 1'b0, 1'b0};
`endif
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 1'b1, 4'd15, 4'd15, 4'd3, 4'd5, g0, g1, v, r, id);
            tests_run++;
            if (g0 !== !exp_id[i] || g1 !== exp_id[i] || v !== 1'b1 ||
                r !== exp_r[i] || id !== exp_id[i]) begin
                tests_failed++;
                $display("FAIL contention_%0d: gnt=%b%b valid=%b res=%0d id=%b, want res=%0d id=%b",
                         i, g0, g1, v, r, id, exp_r[i], exp_id[i]);
            end
        end
        tests_run++;
        if (ops_done !== 16'd3) begin
            tests_failed++;
            $display("FAIL contention_ops: got %0d, want 3", ops_done);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ops_before;
        ops_before = ops_done;
        req1 = 1'b1; a1 = 4'd15; b1 = 4'd1; res_ready = 1'b0;
        step();
        req1 = 1'b0; a1 = 4'd0;
        step();
        for (int i = 0; i < 5; i++) begin
            req0 = 1'b1; req1 = 1'b1;
            #1;
            tests_run++;
            if (res_valid !== 1'b1 || res !== 8'd15 || res_id !== 1'b1 ||
                gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_%0d: valid=%b res=%0d id=%b gnt=%b%b, want 1 15 1 00",
                         i, res_valid, res, res_id, gnt0, gnt1);
            end
            step();
        end
        res_ready = 1'b1;
        #1;
        tests_run++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL accept_nogrant: gnt=%b%b, want 00", gnt0, gnt1);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        tests_run++;
        if (res_valid !== 1'b0 || ops_done !== ops_before + 16'd1) begin
            tests_failed++;
            $display("FAIL stall_accept: valid=%b ops=%0d, want 0 %0d",
                     res_valid, ops_done, ops_before + 16'd1);
        end
    endtask

    task automatic test_reset_mid();
        logic g0, g1, v, id;
        logic [7:0] r;
        req0 = 1'b1; a0 = 4'd6; b0 = 4'd6; res_ready = 1'b1;
        step();
        req0 = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step(); step();
        tests_run++;
        if (res_valid !== 1'b0 || ops_done !== 16'd0) begin
            tests_failed++;
            $display("FAIL abort: valid=%b ops=%0d, want 0 0", res_valid, ops_done);
        end
        run_op(1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 4'd3, g0, g1, v, r, id);
        tests_run++;
        if (g1 !== 1'b1 || g0 !== 1'b0 || v !== 1'b1 || r !== 8'd6 || id !== 1'b1 ||
            ops_done !== 16'd1) begin
            tests_failed++;
            $display("FAIL after_abort: gnt=%b%b valid=%b res=%0d id=%b ops=%0d, want 01 1 6 1 1",
                     g0, g1, v, r, id, ops_done);
        end
    endtask

    task automatic test_extremes();
        logic g0, g1, v, id;
        logic [7:0] r;
        run_op(1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 4'd0, g0, g1, v, r, id);
        tests_run++;
        if (v !== 1'b1 || r !== 8'd0 || id !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_x_15: valid=%b res=%0d id=%b, want 1 0 0", v, r, id);
        end
        run_op(1'b0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd1, g0, g1, v, r, id);
        tests_run++;
        if (v !== 1'b1 || r !== 8'd15 || id !== 1'b1) begin
            tests_failed++;
            $display("FAIL 15_x_1: valid=%b res=%0d id=%b, want 1 15 1", v, r, id);
        end
        run_op(1'b1, 1'b0, 4'd15, 4'd15, 4'd0, 4'd0, g0, g1, v, r, id);
        tests_run++;
        if (v !== 1'b1 || r !== 8'd225) begin
            tests_failed++;
            $display("FAIL 15_x_15: valid=%b res=%0d, want 1 225", v, r);
        end
    endtask

    task automatic test_wrap();
        logic g0, g1, v, id;
        logic [7:0] r;
        force dut.r_ops_done = 16'hFFFF;
        #1;
        release dut.r_ops_done;
        #1;
        tests_run++;
        if (ops_done !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL preload: got %h, want ffff", ops_done);
        end
        step();
        run_op(1'b1, 1'b0, 4'd3, 4'd3, 4'd0, 4'd0, g0, g1, v, r, id);
        tests_run++;
        if (ops_done !== 16'h0000 || r !== 8'd9) begin
            tests_failed++;
            $display("FAIL wrap: ops=%h res=%0d, want 0000 9", ops_done, r);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        rst = 1'b1; step(); rst = 1'b0;
        test_reset_mid();
        test_extremes();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter N, default 4: width of operand A.
REQ-002 Parameter M, default 4: width of operand B.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  requester 0/1 asks for a multiply.
REQ-006 a0, a1  input  N each  requester 0/1 operand A, unsigned.
REQ-007 b0, b1  input  M each  requester 0/1 operand B, unsigned.
REQ-008 gnt0, gnt1  output  1 each  grant; operands of the granted requester are captured on this edge.
REQ-009 res  output  M+N  unsigned product A*B.
REQ-010 res_id  output  1  index of the requester that owns res.
REQ-011 res_valid  output  1  res and res_id are valid.
REQ-012 res_ready  input  1  consumer accepts the result.
REQ-013 ops_done  output  16  count of results accepted (res_valid && res_ready).

Function
REQ-014 The block SHALL share one internal combinational unsigned N x M array multiplier (full M+N-bit product, no truncation) between the two requesters.
REQ-015 The FSM SHALL have three states: IDLE, MUL and OUT.
REQ-016 In IDLE with any req high, the block SHALL assert exactly one gnt combinationally, latch that requester's a/b and index on the clock edge, and move to MUL.
REQ-017 In IDLE with no req high, gnt0 and gnt1 SHALL be 0 and the state SHALL remain IDLE.
REQ-018 In MUL, the block SHALL register the product into res and the index into res_id, then move to OUT; gnt0 and gnt1 SHALL be 0.
REQ-019 In OUT, res_valid SHALL be 1 and res/res_id SHALL hold stable until res_ready is sampled high; the state then returns to IDLE.
REQ-020 Latency SHALL be 2 cycles from the grant edge to res_valid high; minimum issue interval SHALL be 3 cycles.
REQ-021 No grant SHALL be issued in the cycle res_ready is accepted, because the state is OUT, not IDLE.
REQ-022 req inputs SHALL be sampled only in IDLE; req changes in MUL/OUT have no effect.
REQ-023 a/b inputs SHALL be ignored outside the grant cycle.
REQ-024 ops_done SHALL increment by 1 per accepted result and wrap from 0xFFFF to 0x0000.
REQ-025 Operand extremes (all-ones x all-ones, x 0) SHALL yield the exact product, e.g. N=M=4: 15*15=225, 15*0=0.

Reset
REQ-026 While rst is high, the state SHALL go to IDLE and outputs SHALL be: gnt0=gnt1=0, res=0, res_id=0, res_valid=0, ops_done=0.
REQ-027 While rst is high, the round-robin last-grant pointer SHALL be set to 1, so requester 0 wins the first contention.
REQ-028 rst asserted in MUL or OUT SHALL abandon the operation with no result delivered and no ops_done increment.

Configuration
REQ-029 With macro MUL_ARB_RR_EN defined, arbitration SHALL be round-robin: with both req high, grant the requester not granted last; update the pointer on every grant.
REQ-030 Without MUL_ARB_RR_EN, arbitration SHALL be fixed priority, with requester 0 always winning when both req are high, and no pointer register.

Verification
REQ-031 N=M=4: req0 only, a0=7, b0=9, res_ready=1 -> gnt0 pulses 1 cycle; 2 cycles later res_valid=1, res=63, res_id=0; ops_done=1.
REQ-032 req0/req1 held high, a0=15,b0=15, a1=3,b1=5, RR_EN defined -> results alternate: 225 (id 0), 15 (id 1), 225 (id 0); without the macro, all results are 225 (id 0).
REQ-033 res_ready=0 for 5 cycles after res_valid -> res, res_id and res_valid stay stable; no gnt; accepted on the first res_ready=1, then IDLE.
REQ-034 rst pulsed in the MUL cycle of a 6*6 operation -> res_valid stays 0, ops_done=0, and the next req1-only operation, 2*3, yields 6, id 1.
REQ-035 ops_done preloaded by 65535 accepted operations (or forced) -> the next acceptance reads 0x0000.
REQ-036 a0=0, b0=15 -> res=0; a1=15, b1=1 -> res=15.
